// File: rtl/mx_mdio_frame_master.sv
`default_nettype none
// ============================================================================
// Module   : mx_mdio_frame_master
// Purpose  : Clause 22 MDIO master. Accepts one read/write request at a time,
//            serialises it onto MDC/MDIO using a programmable MDC divider and
//            returns read data plus a no-PHY error flag.
// Ports    : clk_i, rst_n_i            - clock, async active-low reset
//            req_valid_i/req_ready_o   - request handshake
//            req_rd_i, req_phy_addr_i, req_reg_addr_i, req_wdata_i
//            rsp_valid_o, rsp_rdata_o, rsp_err_o - completion
//            mdc_o, mdio_o, mdio_oe_o, mdio_i    - management pins
// Revision : 1.0 - initial release
// ============================================================================
module mx_mdio_frame_master #(
  parameter int CLK_DIV     = 32,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_i,
  input  logic [4:0]  req_phy_addr_i,
  input  logic [4:0]  req_reg_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i
);

  localparam logic [3:0] c_idle  = 4'd0;
  localparam logic [3:0] c_pre   = 4'd1;
  localparam logic [3:0] c_st    = 4'd2;
  localparam logic [3:0] c_op    = 4'd3;
  localparam logic [3:0] c_phyad = 4'd4;
  localparam logic [3:0] c_regad = 4'd5;
  localparam logic [3:0] c_ta    = 4'd6;
  localparam logic [3:0] c_data  = 4'd7;
  localparam logic [3:0] c_done  = 4'd8;

  localparam logic [7:0] c_half_reload = 8'(CLK_DIV - 1);
  localparam logic [3:0] c_first_state = PREAMBLE_EN ? c_pre : c_st;
  localparam logic [4:0] c_first_len   = PREAMBLE_EN ? 5'd31 : 5'd1;

  logic [3:0]  r_state, w_state_nxt;
  logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;   // remaining bits in field, MSB-first index
  logic [3:0]  w_next_field;
  logic [4:0]  w_next_len;
  logic [7:0]  r_half_cnt;
  logic        r_mdc;
  logic        r_rd;
  logic [4:0]  r_phy;
  logic [4:0]  r_reg;
  logic [15:0] r_wdata;
  logic [15:0] r_rd_sh;
  logic        r_ta_err;
  logic [15:0] r_rdata;
  logic        r_err;
  logic        r_sync1, r_sync2;
  logic        w_ready, w_active, w_accept, w_half_end, w_bit_end, w_last_bit;
  logic [15:0] w_rd_shift;
  logic        w_mdio, w_oe;

  assign w_ready    = (r_state == c_idle) || (r_state == c_done);
  assign w_active   = (r_state >= c_pre) && (r_state <= c_data);
  assign w_accept   = req_valid_i && w_ready;
  assign w_half_end = (r_half_cnt == 8'd0);
  // A bit ends on the last cycle of its MDC high phase; read bits are sampled here.
  assign w_bit_end  = w_active && r_mdc && w_half_end;
  assign w_last_bit = (r_bit_cnt == 5'd0);
  assign w_rd_shift = {r_rd_sh[14:0], r_sync2};

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= c_idle;
      r_bit_cnt <= 5'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_field = c_idle;
    w_next_len   = 5'd0;
    case (r_state)
      c_pre:   begin w_next_field = c_st;    w_next_len = 5'd1;  end
      c_st:    begin w_next_field = c_op;    w_next_len = 5'd1;  end
      c_op:    begin w_next_field = c_phyad; w_next_len = 5'd4;  end
      c_phyad: begin w_next_field = c_regad; w_next_len = 5'd4;  end
      c_regad: begin w_next_field = c_ta;    w_next_len = 5'd1;  end
      c_ta:    begin w_next_field = c_data;  w_next_len = 5'd15; end
      c_data:  begin w_next_field = c_done;  w_next_len = 5'd0;  end
      default: begin w_next_field = c_idle;  w_next_len = 5'd0;  end
    endcase

    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    if (w_ready) begin
      // DONE accepts too, so back-to-back frames need no idle bit.
      if (w_accept) begin
        w_state_nxt   = c_first_state;
        w_bit_cnt_nxt = c_first_len;
      end else begin
        w_state_nxt = c_idle;
      end
    end else if (!w_active) begin
      w_state_nxt   = c_idle;
      w_bit_cnt_nxt = 5'd0;
    end else if (w_bit_end) begin
      if (w_last_bit) begin
        w_state_nxt   = w_next_field;
        w_bit_cnt_nxt = w_next_len;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt - 5'd1;
      end
    end
  end

  // Output logic: depends only on registered state, so mdio changes only
  // when a new bit begins (first cycle of its MDC low phase).
  always_comb begin
    w_mdio = 1'b1;
    w_oe   = 1'b0;
    case (r_state)
      c_pre:   begin w_oe = 1'b1; w_mdio = 1'b1; end
      c_st:    begin w_oe = 1'b1; w_mdio = ~r_bit_cnt[0]; end
      c_op:    begin w_oe = 1'b1; w_mdio = r_rd ? r_bit_cnt[0] : ~r_bit_cnt[0]; end
      c_phyad: begin w_oe = 1'b1; w_mdio = r_phy[r_bit_cnt[2:0]]; end
      c_regad: begin w_oe = 1'b1; w_mdio = r_reg[r_bit_cnt[2:0]]; end
      c_ta:    begin w_oe = ~r_rd; w_mdio = r_rd ? 1'b1 : r_bit_cnt[0]; end
      c_data:  begin w_oe = ~r_rd; w_mdio = r_rd ? 1'b1 : r_wdata[r_bit_cnt[3:0]]; end
      default: begin w_oe = 1'b0; w_mdio = 1'b1; end
    endcase
  end

  assign mdio_o      = w_mdio;
  assign mdio_oe_o   = w_oe;
  assign mdc_o       = r_mdc;
  assign req_ready_o = w_ready;
  assign rsp_valid_o = (r_state == c_done);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // mdio_i is asynchronous to clk_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= mdio_i;
      r_sync2 <= r_sync1;
    end
  end

  // Request capture, MDC generation and read capture
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_half_cnt <= 8'd0;
      r_mdc      <= 1'b0;
      r_rd       <= 1'b0;
      r_phy      <= 5'd0;
      r_reg      <= 5'd0;
      r_wdata    <= 16'd0;
      r_rd_sh    <= 16'd0;
      r_ta_err   <= 1'b0;
      r_rdata    <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd       <= req_rd_i;
        r_phy      <= req_phy_addr_i;
        r_reg      <= req_reg_addr_i;
        r_wdata    <= req_wdata_i;
        r_half_cnt <= c_half_reload;
        r_mdc      <= 1'b0;
        r_ta_err   <= 1'b0;
      end else if (w_active) begin
        if (w_half_end) begin
          r_mdc      <= ~r_mdc;
          r_half_cnt <= c_half_reload;
        end else begin
          r_half_cnt <= r_half_cnt - 8'd1;
        end
      end

      if (w_bit_end && r_rd) begin
        if ((r_state == c_ta) && w_last_bit) r_ta_err <= r_sync2;
        if (r_state == c_data)               r_rd_sh  <= w_rd_shift;
      end

      // Response is loaded as DONE is entered so it is valid with rsp_valid_o.
      if (w_bit_end && (r_state == c_data) && w_last_bit) begin
        r_rdata <= r_rd ? w_rd_shift : 16'd0;
        r_err   <= r_rd & r_ta_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mx_mdio_frame_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mx_mdio_frame_master
// Purpose  : Directed self-checking bench for mx_mdio_frame_master. Instance
//            dut_a uses CLK_DIV=4 with preamble, dut_b uses CLK_DIV=2 without.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mx_mdio_frame_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_rd = 1'b0;
  logic [4:0]  a_phy = 5'd0, a_reg = 5'd0;
  logic [15:0] a_wdata = 16'd0, a_rdata;
  logic        a_rsp_valid, a_err, a_mdc, a_mdio_o, a_mdio_oe;
  logic        a_mdio_in = 1'b1;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_rd = 1'b0;
  logic [4:0]  b_phy = 5'd0, b_reg = 5'd0;
  logic [15:0] b_wdata = 16'd0, b_rdata;
  logic        b_rsp_valid, b_err, b_mdc, b_mdio_o, b_mdio_oe;
  logic        b_mdio_in = 1'b1;

  mx_mdio_frame_master #(.CLK_DIV(4), .PREAMBLE_EN(1'b1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_rd_i(a_req_rd),
    .req_phy_addr_i(a_phy), .req_reg_addr_i(a_reg), .req_wdata_i(a_wdata),
    .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .rsp_err_o(a_err),
    .mdc_o(a_mdc), .mdio_o(a_mdio_o), .mdio_oe_o(a_mdio_oe), .mdio_i(a_mdio_in)
  );

  mx_mdio_frame_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_rd_i(b_req_rd),
    .req_phy_addr_i(b_phy), .req_reg_addr_i(b_reg), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .rsp_err_o(b_err),
    .mdc_o(b_mdc), .mdio_o(b_mdio_o), .mdio_oe_o(b_mdio_oe), .mdio_i(b_mdio_in)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One frame on dut_a. Called and returns at 1 time unit after a rising edge.
  task automatic frame_a(input string tag, input logic rd, input logic [4:0] pa,
                         input logic [4:0] ra, input logic [15:0] wd,
                         input bit phy_on, input logic [16:0] phy_word, input bit poke,
                         input logic [63:0] exp_bits, input logic [15:0] exp_rdata,
                         input logic exp_err);
    logic [63:0] stream;
    int rises, lat, first_rise, viol_oe, viol_chg, pend, bitidx, extra;
    logic pend_val, prev_mdc, prev_o, prev_oe;
    stream = '0; rises = 0; lat = 0; first_rise = 0; viol_oe = 0; viol_chg = 0;
    pend = 0; pend_val = 1'b1; extra = 0;

    a_req_valid = 1'b1; a_req_rd = rd; a_phy = pa; a_reg = ra; a_wdata = wd;
    @(posedge clk); #1;
    // Scramble request inputs: the frame must use the latched copy.
    a_req_valid = 1'b0; a_req_rd = ~rd; a_phy = ~pa; a_reg = ~ra; a_wdata = ~wd;
    check_val({tag, "_busy"}, a_req_ready, 1'b0);
    check_val({tag, "_first_low"}, a_mdc, 1'b0);
    prev_mdc = a_mdc; prev_o = a_mdio_o; prev_oe = a_mdio_oe;

    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (a_rsp_valid) begin lat = c; break; end
      if (poke && c == 200) begin
        a_req_valid = 1'b1; a_req_rd = 1'b1; a_phy = 5'd0; a_reg = 5'd0;
      end
      if (poke && c == 201) a_req_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) a_mdio_in = pend_val;
      end
      if (c > 1 && (a_mdio_o !== prev_o || a_mdio_oe !== prev_oe) && !(prev_mdc && !a_mdc))
        viol_chg++;
      if (a_mdc && !prev_mdc) begin
        if (first_rise == 0) first_rise = c;
        stream = {stream[62:0], a_mdio_o};
        rises++;
        // PHY drives the next bit 2 cycles after each MDC rise.
        if (phy_on && rises >= 47 && rises <= 63) begin
          pend = 2; pend_val = phy_word[16 - (rises - 47)];
        end else if (phy_on && rises == 64) begin
          pend = 2; pend_val = 1'b1;
        end
      end
      bitidx = a_mdc ? rises - 1 : rises;
      if (a_mdio_oe !== ((rd && bitidx >= 46) ? 1'b0 : 1'b1)) viol_oe++;
      prev_mdc = a_mdc; prev_o = a_mdio_o; prev_oe = a_mdio_oe;
    end

    check_val({tag, "_latency"}, lat, 513);
    check_val({tag, "_first_rise"}, first_rise, 5);
    check_val({tag, "_nbits"}, rises, 64);
    check_val({tag, "_stream"}, stream, exp_bits);
    check_val({tag, "_oe_pattern"}, viol_oe, 0);
    check_val({tag, "_change_point"}, viol_chg, 0);
    check_val({tag, "_rsp"}, {exp_err, a_rdata}, {exp_err, exp_rdata});
    check_val({tag, "_err"}, a_err, exp_err);
    check_val({tag, "_done_pins"}, {a_req_ready, a_mdc, a_mdio_oe}, 3'b100);

    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (a_rsp_valid || a_mdc || !a_req_ready || a_mdio_oe || !a_mdio_o) extra++;
    end
    check_val({tag, "_idle_after"}, extra, 0);
    check_val({tag, "_rdata_held"}, a_rdata, exp_rdata);
    a_mdio_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] st;
    int v1, v2, nv, rises, fr2, quiet;
    logic prev_mdc;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_state", {a_req_ready, a_rsp_valid, a_err, a_mdc, a_mdio_o, a_mdio_oe, a_rdata},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_state", {a_req_ready, a_mdc, a_mdio_o, a_mdio_oe, b_req_ready},
              {1'b1, 1'b0, 1'b1, 1'b0, 1'b1});

    frame_a("wr_a5c3", 1'b0, 5'h03, 5'h1F, 16'hA5C3, 1'b0, 17'h0, 1'b0,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, 5'h1F, 2'b10, 16'hA5C3}, 16'h0000, 1'b0);
    frame_a("rd_1234", 1'b1, 5'h01, 5'h02, 16'hDEAD, 1'b1, {1'b0, 16'h1234}, 1'b0,
            {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h02, 18'h3FFFF}, 16'h1234, 1'b0);
    frame_a("rd_ta1", 1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, {1'b1, 16'h8001}, 1'b0,
            {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h02, 18'h3FFFF}, 16'h8001, 1'b1);
    frame_a("rd_nophy", 1'b1, 5'h1F, 5'h00, 16'h0000, 1'b0, 17'h0, 1'b0,
            {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h00, 18'h3FFFF}, 16'hFFFF, 1'b1);

    // Reset in the middle of the DATA phase of a write
    a_req_valid = 1'b1; a_req_rd = 1'b0; a_phy = 5'h05; a_reg = 5'h0A; a_wdata = 16'hFFFF;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    repeat (450) @(posedge clk);
    #1;
    check_val("rst_pre_busy", {a_req_ready, a_mdio_oe}, 2'b01);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst_async", {a_req_ready, a_rsp_valid, a_err, a_mdc, a_mdio_o, a_mdio_oe, a_rdata},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000});
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (a_rsp_valid || a_mdc || !a_req_ready) quiet++;
    end
    check_val("rst_no_rsp", quiet, 0);

    frame_a("wr_after_rst", 1'b0, 5'h12, 5'h00, 16'h0001, 1'b0, 17'h0, 1'b0,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h12, 5'h00, 2'b10, 16'h0001}, 16'h0000, 1'b0);
    frame_a("wr_poke", 1'b0, 5'h1A, 5'h07, 16'h5A0F, 1'b0, 17'h0, 1'b1,
            {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h1A, 5'h07, 2'b10, 16'h5A0F}, 16'h0000, 1'b0);

    // Back-to-back writes on dut_b with req_valid held high
    st = '0; v1 = 0; v2 = 0; nv = 0; rises = 0; fr2 = 0; prev_mdc = 1'b0;
    b_req_valid = 1'b1; b_req_rd = 1'b0; b_phy = 5'h11; b_reg = 5'h05; b_wdata = 16'h0F0F;
    @(posedge clk); #1;
    check_val("b2b_busy", b_req_ready, 1'b0);
    for (int c = 1; c <= 600; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (b_mdc && !prev_mdc) begin
        rises++;
        st = {st[62:0], b_mdio_o};
        if (v1 != 0 && fr2 == 0) fr2 = c;
      end
      prev_mdc = b_mdc;
      if (v1 != 0 && c == v1 + 1) begin
        b_req_valid = 1'b0;
        check_val("b2b_restart", {b_mdc, b_req_ready, b_mdio_oe, b_mdio_o}, 4'b0010);
      end
      if (b_rsp_valid) begin
        nv++;
        if (nv == 1) begin
          v1 = c;
          check_val("b2b_done_pins", {b_req_ready, b_mdc, b_mdio_oe}, 3'b100);
        end else begin
          v2 = c;
          break;
        end
      end
    end
    check_val("b2b_lat1", v1, 129);
    check_val("b2b_lat2", v2, 258);
    check_val("b2b_fr2_rise", fr2, 132);
    check_val("b2b_nbits", rises, 64);
    check_val("b2b_stream", st, {2'b01, 2'b01, 5'h11, 5'h05, 2'b10, 16'h0F0F,
                                 2'b01, 2'b01, 5'h11, 5'h05, 2'b10, 16'h0F0F});
    check_val("b2b_resp", {b_err, b_rdata}, 17'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
